// File: rtl/cnt_seg7_pkg.sv
// cnt_seg7_pkg: shared constants, BCD digit type and hex-to-segment table
// for the counter display.
`default_nettype none
`timescale 1ns/1ps

package cnt_seg7_pkg;

  localparam int         BCD_W     = 4;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [3:0] AN_OFF    = 4'hF;

  typedef logic [BCD_W-1:0] bcd_digit_t;

  // Active-low {g,f,e,d,c,b,a}
  function automatic logic [6:0] hex2seg(input logic [3:0] hex);
    logic [6:0] s;
    case (hex)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

endpackage

`default_nettype wire

// File: rtl/seg7_decode.sv
// seg7_decode: combinational hex digit to active-low 7-segment pattern.
`default_nettype none
`timescale 1ns/1ps

module seg7_decode
  import cnt_seg7_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  assign seg = hex2seg(hex);

endmodule

`default_nettype wire

// File: rtl/cnt_seg7_display.sv
// cnt_seg7_display: counts wraps of an upstream 4-bit counter in 3-digit BCD
// and scans a 4-digit common-anode display. Option: LEADING_ZERO_BLANK_EN.
`default_nettype none
`timescale 1ns/1ps

module cnt_seg7_display
  import cnt_seg7_pkg::*;
#(
  parameter int SCAN_DIV = 50000,
  parameter int CNT_MAX  = 15
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [3:0] cnt,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       wrap_pulse,
  output logic       ovf
);

  localparam int SCAN_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

  logic [3:0]        prev_cnt;
  bcd_digit_t        units, tens, hund;
  bcd_digit_t        units_nx, tens_nx, hund_nx;
  logic              roll_over;
  logic              wrap;
  logic [SCAN_W-1:0] scan_cnt;
  logic [1:0]        digit_sel;
  logic [3:0]        digit_val;
  logic              blank;
  logic [6:0]        dec_seg;

  assign wrap = (prev_cnt == 4'(CNT_MAX)) && (cnt == 4'd0);

  // Decimal carry chain for a single increment
  always_comb begin
    units_nx  = units + 4'd1;
    tens_nx   = tens;
    hund_nx   = hund;
    roll_over = 1'b0;
    if (units == 4'd9) begin
      units_nx = 4'd0;
      tens_nx  = tens + 4'd1;
      if (tens == 4'd9) begin
        tens_nx = 4'd0;
        hund_nx = hund + 4'd1;
        if (hund == 4'd9) begin
          hund_nx   = 4'd0;
          roll_over = 1'b1;
        end
      end
    end
  end

  always_comb begin
    digit_val = prev_cnt;
    blank     = 1'b0;
    case (digit_sel)
      2'd1:    digit_val = units;
      2'd2:    digit_val = tens;
      2'd3:    digit_val = hund;
      default: digit_val = prev_cnt;
    endcase
`ifdef LEADING_ZERO_BLANK_EN
    case (digit_sel)
      2'd1:    blank = (units == 4'd0) && (tens == 4'd0) && (hund == 4'd0);
      2'd2:    blank = (tens == 4'd0) && (hund == 4'd0);
      2'd3:    blank = (hund == 4'd0);
      default: blank = 1'b0;
    endcase
`else
    blank = 1'b0;
`endif
  end

  seg7_decode u_decode (
    .hex (digit_val),
    .seg (dec_seg)
  );

  always_ff @(posedge clk) begin
    if (!rstn) begin
      prev_cnt   <= 4'd0;
      units      <= 4'd0;
      tens       <= 4'd0;
      hund       <= 4'd0;
      ovf        <= 1'b0;
      wrap_pulse <= 1'b0;
      scan_cnt   <= '0;
      digit_sel  <= 2'd0;
      an         <= AN_OFF;
      seg        <= SEG_BLANK;
      dp         <= 1'b1;
    end else begin
      prev_cnt   <= cnt;
      wrap_pulse <= wrap;
      if (wrap) begin
        units <= units_nx;
        tens  <= tens_nx;
        hund  <= hund_nx;
        if (roll_over) ovf <= 1'b1;
      end
      if (scan_cnt == SCAN_W'(SCAN_DIV - 1)) begin
        scan_cnt  <= '0;
        digit_sel <= digit_sel + 2'd1;
      end else begin
        scan_cnt <= scan_cnt + 1'b1;
      end
      // Outputs follow the digit selected during the previous cycle
      an  <= ~(4'b0001 << digit_sel);
      seg <= blank ? SEG_BLANK : dec_seg;
      dp  <= ~((digit_sel == 2'd3) && ovf);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_cnt_seg7_display.sv
// tb_cnt_seg7_display: directed self-checking bench for cnt_seg7_display
// with SCAN_DIV=4, CNT_MAX=15.
`default_nettype none
`timescale 1ns/1ps

module tb_cnt_seg7_display;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic [3:0] cnt = 4'd0;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;
  logic       wrap_pulse;
  logic       ovf;

  int checks = 0;
  int errors = 0;

`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [6:0] ZB = 7'h7F;
`else
  localparam logic [6:0] ZB = 7'h40;
`endif

  cnt_seg7_display #(.SCAN_DIV(4), .CNT_MAX(15)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .cnt        (cnt),
    .an         (an),
    .seg        (seg),
    .dp         (dp),
    .wrap_pulse (wrap_pulse),
    .ovf        (ovf)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    step();
    step();
    rstn = 1'b1;
  endtask

  // Collects one full scan and compares each digit's segments and dp
  task automatic read_display(input string name, input logic [6:0] e0,
                              input logic [6:0] e1, input logic [6:0] e2,
                              input logic [6:0] e3, input logic [3:0] exp_dp);
    logic [6:0] got_seg [4];
    logic [3:0] got_dp;
    logic [3:0] seen;
    logic [6:0] exp_seg [4];
    int idx;
    seen = 4'd0;
    got_dp = 4'd0;
    for (int k = 0; k < 4; k++) got_seg[k] = 7'h00;
    exp_seg[0] = e0; exp_seg[1] = e1; exp_seg[2] = e2; exp_seg[3] = e3;
    for (int n = 0; n < 24 && seen != 4'hF; n++) begin
      step();
      case (an)
        4'b1110: idx = 0;
        4'b1101: idx = 1;
        4'b1011: idx = 2;
        4'b0111: idx = 3;
        default: idx = -1;
      endcase
      if (idx >= 0) begin
        got_seg[idx] = seg;
        got_dp[idx]  = dp;
        seen[idx]    = 1'b1;
      end
    end
    checks++;
    if (seen !== 4'hF) begin
      errors++;
      $display("FAIL %s scan_timeout: digits seen %b, required 1111", name, seen);
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (got_seg[k] !== exp_seg[k]) begin
        errors++;
        $display("FAIL %s seg_digit%0d: got %h, required %h", name, k, got_seg[k], exp_seg[k]);
      end
    end
    checks++;
    if (got_dp !== exp_dp) begin
      errors++;
      $display("FAIL %s dp_per_digit: got %b, required %b", name, got_dp, exp_dp);
    end
  endtask

  task automatic drive_wraps(input int n, output int pulses);
    pulses = 0;
    for (int i = 0; i < n; i++) begin
      cnt = 4'd15;
      step();
      if (wrap_pulse) pulses++;
      cnt = 4'd0;
      step();
      if (wrap_pulse) pulses++;
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cnt = 4'(i * 5 + 3);
      step();
      checks++;
      if (an !== 4'b1111 || seg !== 7'h7F || dp !== 1'b1 || wrap_pulse !== 1'b0 || ovf !== 1'b0) begin
        errors++;
        $display("FAIL reset_outputs cycle %0d: an=%b seg=%h dp=%b wp=%b ovf=%b, required 1111 7f 1 0 0",
                 i, an, seg, dp, wrap_pulse, ovf);
      end
    end
  endtask

  task automatic test_ramp();
    int pulses;
    pulses = 0;
    rstn = 1'b1;
    for (int v = 0; v < 16; v++) begin
      cnt = 4'(v);
      step();
      if (wrap_pulse !== 1'b0) pulses++;
    end
    checks++;
    if (pulses != 0) begin
      errors++;
      $display("FAIL ramp_no_early_pulse: got %0d pulses, required 0", pulses);
    end
    cnt = 4'd0;
    step();
    checks++;
    if (wrap_pulse !== 1'b1) begin
      errors++;
      $display("FAIL ramp_wrap_pulse: got %b, required 1", wrap_pulse);
    end
    step();
    checks++;
    if (wrap_pulse !== 1'b0) begin
      errors++;
      $display("FAIL ramp_pulse_width: got %b, required 0", wrap_pulse);
    end
    read_display("ramp", 7'h40, 7'h79, ZB, ZB, 4'b1111);
  endtask

  task automatic test_jumps();
    int pulses;
    pulses = 0;
    cnt = 4'd15; step(); if (wrap_pulse) pulses++;
    cnt = 4'd3;  step(); if (wrap_pulse) pulses++;
    cnt = 4'd7;  step(); if (wrap_pulse) pulses++;
    cnt = 4'd0;  step(); if (wrap_pulse) pulses++;
    step();              if (wrap_pulse) pulses++;
    checks++;
    if (pulses != 0) begin
      errors++;
      $display("FAIL jumps_no_wrap: got %0d pulses, required 0", pulses);
    end
    read_display("jumps", 7'h40, 7'h79, ZB, ZB, 4'b1111);
  endtask

  task automatic test_scan();
    logic [3:0] exp_an;
    int seg_bad;
    seg_bad = 0;
    cnt = 4'hA;
    do_reset();
    for (int n = 1; n <= 24; n++) begin
      step();
      exp_an = ~(4'b0001 << (((n - 1) / 4) % 4));
      checks++;
      if (an !== exp_an) begin
        errors++;
        $display("FAIL scan_an cycle %0d: got %b, required %b", n, an, exp_an);
      end
      if (n > 1 && an == 4'b1110 && seg !== 7'h08) seg_bad++;
    end
    checks++;
    if (seg_bad != 0) begin
      errors++;
      $display("FAIL scan_digit0_hexA: %0d cycles with wrong seg, required 0 (seg 08)", seg_bad);
    end
  endtask

  task automatic test_overflow();
    int pulses, more;
    do_reset();
    drive_wraps(999, pulses);
    checks++;
    if (ovf !== 1'b0) begin
      errors++;
      $display("FAIL ovf_before_999: got %b, required 0", ovf);
    end
    drive_wraps(1, more);
    pulses += more;
    checks++;
    if (pulses != 1000) begin
      errors++;
      $display("FAIL ovf_pulse_count: got %0d, required 1000", pulses);
    end
    step();
    checks++;
    if (ovf !== 1'b1) begin
      errors++;
      $display("FAIL ovf_set: got %b, required 1", ovf);
    end
    read_display("ovf", 7'h40, ZB, ZB, ZB, 4'b0111);
    checks++;
    if (ovf !== 1'b1) begin
      errors++;
      $display("FAIL ovf_sticky: got %b, required 1", ovf);
    end
  endtask

  task automatic test_blank_007();
    int pulses;
    do_reset();
    drive_wraps(7, pulses);
    cnt = 4'd7;
    step();
    step();
    read_display("bcd007", 7'h78, 7'h78, ZB, ZB, 4'b1111);
  endtask

  task automatic test_midreset();
    int pulses;
    int budget;
    do_reset();
    drive_wraps(42, pulses);
    cnt = 4'd5;
    step();
    step();
    read_display("bcd042", 7'h12, 7'h24, 7'h19, ZB, 4'b1111);
    budget = 0;
    while (an != 4'b1011 && budget < 20) begin
      step();
      budget++;
    end
    checks++;
    if (an !== 4'b1011) begin
      errors++;
      $display("FAIL midreset_wait_digit2: got an=%b, required 1011", an);
    end
    rstn = 1'b0;
    step();
    checks++;
    if (an !== 4'b1111 || seg !== 7'h7F || dp !== 1'b1 || wrap_pulse !== 1'b0 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL midreset_outputs: an=%b seg=%h dp=%b wp=%b ovf=%b, required 1111 7f 1 0 0",
               an, seg, dp, wrap_pulse, ovf);
    end
    rstn = 1'b1;
    step();
    checks++;
    if (an !== 4'b1110) begin
      errors++;
      $display("FAIL midreset_scan_restart: got an=%b, required 1110", an);
    end
    read_display("after_midreset", 7'h12, ZB, ZB, ZB, 4'b1111);
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_jumps();
    test_scan();
    test_overflow();
    test_blank_007();
    test_midreset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
